// File: rtl/processor_no_mem.sv
// Multicycle RV32I execution core without memories: one instruction per
// FETCH/DECODE/EXECUTE/WRITEBACK pass, full state exported on regValues.
module processor_no_mem #(
    parameter int XLEN    = 32,
    parameter int NUM_GPR = 32,
    parameter int NUM_DBG = 39
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [XLEN-1:0]        command,
    input  logic                   run,
    output logic                   done,
    output logic signed [XLEN-1:0] regValues [NUM_DBG-1:0]
);

    typedef enum logic [1:0] {
        FETCH     = 2'd0,
        DECODE    = 2'd1,
        EXECUTE   = 2'd2,
        WRITEBACK = 2'd3
    } state_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_AUI = 7'b0010111;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JLR = 7'b1100111;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_ST  = 7'b0100011;

    state_t            state;
    logic [XLEN-1:0]   gpr [NUM_GPR];
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   ir;
    logic [XLEN-1:0]   alu;
    logic [XLEN-1:0]   opa;
    logic [XLEN-1:0]   opb;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   npc;
    logic              wen;

    logic [6:0]        opcode;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        f3;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign f3     = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];

    logic is_op, is_opi, is_lui, is_aui;
    logic is_jal, is_jlr, is_br, is_st;

    assign is_op  = (opcode == OP_R);
    assign is_opi = (opcode == OP_I);
    assign is_lui = (opcode == OP_LUI);
    assign is_aui = (opcode == OP_AUI);
    assign is_jal = (opcode == OP_JAL);
    assign is_jlr = (opcode == OP_JLR);
    assign is_br  = (opcode == OP_BR);
    assign is_st  = (opcode == OP_ST);

    logic [XLEN-1:0] imm_d;

    always_comb begin
        imm_d = {{(XLEN-11){ir[31]}}, ir[30:20]};
        unique case (1'b1)
            is_lui, is_aui:
                imm_d = {ir[31:12], 12'b0};
            is_jal:
                imm_d = {{(XLEN-20){ir[31]}}, ir[19:12],
                         ir[20], ir[30:21], 1'b0};
            is_br:
                imm_d = {{(XLEN-12){ir[31]}}, ir[7],
                         ir[30:25], ir[11:8], 1'b0};
            is_st:
                imm_d = {{(XLEN-11){ir[31]}}, ir[30:25], ir[11:7]};
            default: ;
        endcase
    end

    // OP-IMM only honours the alternate bit on right shifts (SRAI)
    logic            alt;
    logic [XLEN-1:0] src_b;
    logic [4:0]      shamt;
    logic [XLEN-1:0] sra_res;
    logic [XLEN-1:0] arith;
    logic            lt_s;
    logic            lt_u;

    assign src_b   = is_op ? opb : imm;
    assign shamt   = src_b[4:0];
    assign alt     = ir[30] & (is_op | (f3 == 3'b101));
    assign sra_res = $signed(opa) >>> shamt;
    assign lt_s    = $signed(opa) < $signed(src_b);
    assign lt_u    = opa < src_b;

    always_comb begin
        arith = '0;
        unique case (f3)
            3'b000: arith = alt ? opa - src_b : opa + src_b;
            3'b001: arith = opa << shamt;
            3'b010: arith = {{(XLEN-1){1'b0}}, lt_s};
            3'b011: arith = {{(XLEN-1){1'b0}}, lt_u};
            3'b100: arith = opa ^ src_b;
            3'b101: arith = alt ? sra_res : opa >> shamt;
            3'b110: arith = opa | src_b;
            3'b111: arith = opa & src_b;
        endcase
    end

    logic taken;

    always_comb begin
        taken = 1'b0;
        case (f3)
            3'b000:  taken = (opa == opb);
            3'b001:  taken = (opa != opb);
            3'b100:  taken = $signed(opa) < $signed(opb);
            3'b101:  taken = $signed(opa) >= $signed(opb);
            3'b110:  taken = opa < opb;
            3'b111:  taken = opa >= opb;
            default: taken = 1'b0;
        endcase
    end

    logic [XLEN-1:0] alu_d;
    logic [XLEN-1:0] npc_d;
    logic            wen_d;
    logic [XLEN-1:0] pc_seq;

    assign pc_seq = pc + 32'd4;

    always_comb begin
        alu_d = arith;
        npc_d = pc_seq;
        wen_d = 1'b0;
        unique case (1'b1)
            is_op, is_opi: wen_d = 1'b1;
            is_lui: begin
                alu_d = imm;
                wen_d = 1'b1;
            end
            is_aui: begin
                alu_d = pc + imm;
                wen_d = 1'b1;
            end
            is_jal: begin
                alu_d = pc_seq;
                npc_d = pc + imm;
                wen_d = 1'b1;
            end
            is_jlr: begin
                alu_d = pc_seq;
                npc_d = (opa + imm) & ~32'd1;
                wen_d = 1'b1;
            end
            is_br: begin
                alu_d = pc + imm;
                npc_d = taken ? pc + imm : pc_seq;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
            pc    <= '0;
            ir    <= '0;
            alu   <= '0;
            opa   <= '0;
            opb   <= '0;
            imm   <= '0;
            npc   <= '0;
            wen   <= 1'b0;
            done  <= 1'b0;
            for (int i = 0; i < NUM_GPR; i++) gpr[i] <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                FETCH: begin
                    ir    <= command;
                    state <= DECODE;
                end
                DECODE: begin
                    opa   <= gpr[rs1];
                    opb   <= gpr[rs2];
                    imm   <= imm_d;
                    state <= EXECUTE;
                end
                EXECUTE: begin
                    alu   <= alu_d;
                    npc   <= npc_d;
                    wen   <= wen_d;
                    state <= WRITEBACK;
                end
                WRITEBACK: begin
                    if (wen && rd != 5'd0) gpr[rd] <= alu;
                    if (run) pc <= npc;
                    done  <= 1'b1;
                    state <= FETCH;
                end
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_GPR; i++) regValues[i] = gpr[i];
        regValues[32] = pc;
        regValues[33] = ir;
        regValues[34] = alu;
        regValues[35] = opa;
        regValues[36] = opb;
        regValues[37] = imm;
        regValues[38] = {{(XLEN-2){1'b0}}, state};
    end

endmodule

// File: tb/tb_processor_no_mem.sv
// Bench for processor_no_mem: directed plan sequence, mid-instruction reset
// and random instruction streams against an arithmetic reference model.
module tb_processor_no_mem;

    logic               clk = 1'b0;
    logic               reset;
    logic               run;
    logic [31:0]        command;
    logic               done;
    logic signed [31:0] regValues [38:0];

    int checks = 0;
    int errors = 0;

    logic [31:0] m_x [32];
    logic [31:0] m_pc;

    processor_no_mem dut (
        .clk       (clk),
        .reset     (reset),
        .command   (command),
        .run       (run),
        .done      (done),
        .regValues (regValues)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2,
        logic [4:0] rs1, logic [2:0] f3, logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1,
        logic [2:0] f3, logic [4:0] rd, logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_u(logic [19:0] imm, logic [4:0] rd,
        logic [6:0] op);
        return {imm, rd, op};
    endfunction

    function automatic logic [31:0] enc_j(logic [20:0] imm, logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] enc_b(logic [12:0] imm, logic [4:0] rs2,
        logic [4:0] rs1, logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11],
                7'b1100011};
    endfunction

    // Reference ALU in 64-bit integer arithmetic (shifts as mul/div by 2^n)
    function automatic logic [31:0] alu_model(logic [2:0] f3, logic alt,
        logic [31:0] a, logic [31:0] b);
        longint sa, sb, ua, ub, p2, t;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        p2 = longint'(1) << b[4:0];
        t  = 0;
        case (f3)
            3'd0: t = alt ? sa - sb : sa + sb;
            3'd1: t = ua * p2;
            3'd2: t = (sa < sb) ? 1 : 0;
            3'd3: t = (ua < ub) ? 1 : 0;
            3'd4: t = ua ^ ub;
            3'd5: begin
                if (!alt) t = ua / p2;
                else if (sa < 0) t = (sa - (p2 - 1)) / p2;
                else t = sa / p2;
            end
            3'd6: t = ua | ub;
            default: t = ua & ub;
        endcase
        return t[31:0];
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) m_x[i] = '0;
        m_pc = '0;
    endfunction

    function automatic void model_exec(logic [31:0] in);
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [31:0] a, b, res, nxt, ii, bi, ji, ui;
        longint      sa, sb, ua, ub;
        bit          wr, tk;
        rd  = in[11:7];
        f3  = in[14:12];
        rs1 = in[19:15];
        rs2 = in[24:20];
        a   = m_x[rs1];
        b   = m_x[rs2];
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'b0, a});
        ub  = longint'({32'b0, b});
        ii  = 32'($signed(in[31:20]));
        bi  = 32'($signed({in[31], in[7], in[30:25], in[11:8], 1'b0}));
        ji  = 32'($signed({in[31], in[19:12], in[20], in[30:21], 1'b0}));
        ui  = {in[31:12], 12'b0};
        nxt = m_pc + 32'd4;
        res = '0;
        wr  = 0;
        tk  = 0;
        case (in[6:0])
            7'b0110011: begin
                res = alu_model(f3, in[30], a, b);
                wr  = 1;
            end
            7'b0010011: begin
                res = alu_model(f3, in[30] && f3 == 3'd5, a, ii);
                wr  = 1;
            end
            7'b0110111: begin
                res = ui;
                wr  = 1;
            end
            7'b0010111: begin
                res = m_pc + ui;
                wr  = 1;
            end
            7'b1101111: begin
                res = m_pc + 32'd4;
                nxt = m_pc + ji;
                wr  = 1;
            end
            7'b1100111: begin
                res = m_pc + 32'd4;
                nxt = (a + ii) & 32'hFFFF_FFFE;
                wr  = 1;
            end
            7'b1100011: begin
                case (f3)
                    3'd0: tk = (a == b);
                    3'd1: tk = (a != b);
                    3'd4: tk = (sa < sb);
                    3'd5: tk = (sa >= sb);
                    3'd6: tk = (ua < ub);
                    3'd7: tk = (ua >= ub);
                    default: tk = 0;
                endcase
                if (tk) nxt = m_pc + bi;
            end
            default: ;
        endcase
        if (wr && rd != 5'd0) m_x[rd] = res;
        if (run) m_pc = nxt;
    endfunction

    // Present one instruction at a FETCH boundary and run its four edges
    task automatic issue(input logic [31:0] instr, input logic r,
        output logic [3:0] dseq);
        command = instr;
        run     = r;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            dseq[k] = done;
        end
        model_exec(instr);
    endtask

    task automatic test_reset();
        logic [3:0] ds;
        reset   = 1'b0;
        run     = 1'b0;
        command = '0;
        model_reset();
        #20;
        for (int i = 0; i < 39; i++) begin
            checks++;
            if (regValues[i] !== 32'sd0) begin
                errors++;
                $display("FAIL reset_reg%0d: got %0h expected 0",
                         i, regValues[i]);
            end
        end
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done: got %b expected 0", done);
        end
        @(negedge clk);
        reset = 1'b1;
        issue(enc_i(12'd10, 5'd0, 3'd0, 5'd1, 7'b0010011), 1'b0, ds);
        checks++;
        if (regValues[1] !== 32'sd10) begin
            errors++;
            $display("FAIL first_addi: got %0d expected 10", regValues[1]);
        end
        checks++;
        if (ds !== 4'b1000) begin
            errors++;
            $display("FAIL first_done: got %b expected 1000", ds);
        end
        checks++;
        if (regValues[0] !== 32'sd0) begin
            errors++;
            $display("FAIL first_x0: got %0d expected 0", regValues[0]);
        end
    endtask

    task automatic test_alu();
        logic [31:0] ins [12];
        int          rd  [12];
        int          exp [12];
        logic [3:0]  ds;
        ins[0]  = enc_i(12'hFFC, 5'd0, 3'd0, 5'd2, 7'b0010011);
        ins[1]  = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3);
        ins[2]  = enc_r(7'h20, 5'd1, 5'd2, 3'd0, 5'd4);
        ins[3]  = enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd4);
        ins[4]  = enc_r(7'h00, 5'd1, 5'd2, 3'd2, 5'd5);
        ins[5]  = enc_r(7'h00, 5'd2, 5'd0, 3'd3, 5'd6);
        ins[6]  = enc_r(7'h00, 5'd3, 5'd1, 3'd7, 5'd7);
        ins[7]  = enc_r(7'h00, 5'd3, 5'd1, 3'd6, 5'd8);
        ins[8]  = enc_r(7'h00, 5'd3, 5'd1, 3'd4, 5'd9);
        ins[9]  = enc_r(7'h00, 5'd7, 5'd2, 3'd1, 5'd10);
        ins[10] = enc_r(7'h00, 5'd7, 5'd2, 3'd5, 5'd11);
        ins[11] = enc_r(7'h20, 5'd7, 5'd2, 3'd5, 5'd12);
        rd  = '{2, 3, 4, 4, 5, 6, 7, 8, 9, 10, 11, 12};
        exp = '{-4, 6, -14, 14, 1, 1, 2, 14, 12, -16, 1073741823, -1};
        for (int i = 0; i < 12; i++) begin
            issue(ins[i], 1'b0, ds);
            checks++;
            if (regValues[rd[i]] !== exp[i]) begin
                errors++;
                $display("FAIL alu_%0d x%0d: got %0d expected %0d",
                         i, rd[i], regValues[rd[i]], exp[i]);
            end
            checks++;
            if (regValues[33] !== ins[i]) begin
                errors++;
                $display("FAIL alu_ir_%0d: got %0h expected %0h",
                         i, regValues[33], ins[i]);
            end
        end
        checks++;
        if (regValues[32] !== 32'sd0) begin
            errors++;
            $display("FAIL alu_pc_hold: got %0d expected 0", regValues[32]);
        end
    endtask

    task automatic test_control();
        logic [3:0] ds;
        issue(enc_j(21'd8, 5'd13), 1'b1, ds);
        checks++;
        if (regValues[13] !== 32'sd4 || regValues[32] !== 32'sd8) begin
            errors++;
            $display("FAIL jal: got x13=%0d pc=%0d expected 4 8",
                     regValues[13], regValues[32]);
        end
        issue(enc_b(13'h1FF8, 5'd0, 5'd0, 3'd0), 1'b1, ds);
        checks++;
        if (regValues[32] !== 32'sd0) begin
            errors++;
            $display("FAIL beq: got pc=%0d expected 0", regValues[32]);
        end
        issue(enc_u(20'h12345, 5'd14, 7'b0110111), 1'b1, ds);
        checks++;
        if (regValues[14] !== 32'sh12345000 || regValues[32] !== 32'sd4) begin
            errors++;
            $display("FAIL lui: got x14=%0h pc=%0d expected 12345000 4",
                     regValues[14], regValues[32]);
        end
        issue(enc_i(12'd5, 5'd0, 3'd0, 5'd0, 7'b0010011), 1'b0, ds);
        checks++;
        if (regValues[32] !== 32'sd4) begin
            errors++;
            $display("FAIL run0_pc: got %0d expected 4", regValues[32]);
        end
        checks++;
        if (regValues[0] !== 32'sd0) begin
            errors++;
            $display("FAIL x0_write: got %0d expected 0", regValues[0]);
        end
        checks++;
        if (ds !== 4'b1000 || regValues[38] !== 32'sd0) begin
            errors++;
            $display("FAIL wb_done_state: got %b/%0d expected 1000/0",
                     ds, regValues[38]);
        end
    endtask

    task automatic test_reset_mid();
        command = enc_i(12'd7, 5'd0, 3'd0, 5'd15, 7'b0010011);
        run     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (regValues[38] !== 32'sd2) begin
            errors++;
            $display("FAIL mid_state_pre: got %0d expected 2", regValues[38]);
        end
        reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if (regValues[15] !== 32'sd0 || regValues[1] !== 32'sd0) begin
            errors++;
            $display("FAIL mid_regs: got x15=%0d x1=%0d expected 0 0",
                     regValues[15], regValues[1]);
        end
        checks++;
        if (regValues[38] !== 32'sd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mid_state: got %0d/%b expected 0/0",
                     regValues[38], done);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (regValues[15] !== 32'sd0 || regValues[32] !== 32'sd0) begin
            errors++;
            $display("FAIL mid_hold: got x15=%0d pc=%0d expected 0 0",
                     regValues[15], regValues[32]);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [11:0] im;
        logic [20:0] jm;
        logic [12:0] bm;
        logic [6:0]  f7;
        logic [2:0]  bf  [6];
        logic [6:0]  nop [4];
        bf  = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        nop = '{7'b0000011, 7'b0100011, 7'b1110011, 7'b0001111};
        r   = $urandom;
        rd  = 5'($urandom_range(0, 31));
        rs1 = 5'($urandom_range(0, 31));
        rs2 = 5'($urandom_range(0, 31));
        f3  = 3'($urandom_range(0, 7));
        case ($urandom_range(0, 9))
            0, 1: begin
                f7 = ((f3 == 3'd0 || f3 == 3'd5) && r[31]) ? 7'h20 : 7'h00;
                return enc_r(f7, rs2, rs1, f3, rd);
            end
            2, 3: begin
                im = r[11:0];
                if (f3 == 3'd1) im = {7'h00, r[4:0]};
                if (f3 == 3'd5) im = {r[31] ? 7'h20 : 7'h00, r[4:0]};
                return enc_i(im, rs1, f3, rd, 7'b0010011);
            end
            4: return enc_u(r[19:0], rd, 7'b0110111);
            5: return enc_u(r[19:0], rd, 7'b0010111);
            6: begin
                jm    = r[20:0];
                jm[0] = 1'b0;
                return enc_j(jm, rd);
            end
            7: return enc_i(r[11:0], rs1, 3'd0, rd, 7'b1100111);
            8: begin
                bm    = r[12:0];
                bm[0] = 1'b0;
                return enc_b(bm, rs2, rs1, bf[$urandom_range(0, 5)]);
            end
            default: return {r[31:7], nop[$urandom_range(0, 3)]};
        endcase
    endfunction

    task automatic test_random();
        logic [31:0] in;
        logic [3:0]  ds;
        for (int n = 0; n < 200; n++) begin
            in = rand_instr();
            issue(in, 1'($urandom_range(0, 1)), ds);
            for (int i = 0; i < 32; i++) begin
                checks++;
                if (regValues[i] !== m_x[i]) begin
                    errors++;
                    $display("FAIL rand_%0d x%0d: got %0h expected %0h ir %0h",
                             n, i, regValues[i], m_x[i], in);
                end
            end
            checks++;
            if (regValues[32] !== m_pc) begin
                errors++;
                $display("FAIL rand_%0d pc: got %0h expected %0h ir %0h",
                         n, regValues[32], m_pc, in);
            end
            checks++;
            if (ds !== 4'b1000) begin
                errors++;
                $display("FAIL rand_%0d done: got %b expected 1000", n, ds);
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_control();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
